// File: rtl/keypad_encoder.sv
// ---------------------------------------------------------------------------
// keypad_encoder
//
// Scans a 4x4 active-low matrix keypad. It drives one column low at a time,
// debounces both press and release, and encodes the accepted key as
// row_idx*4 + col_idx.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rows[3:0]  keypad rows, active-low, asynchronous (external pull-ups)
//   cols[3:0]  column drive, exactly one bit low at all times (registered)
//   key_code   code of the last accepted key, held until the next accept
//   key_valid  one-clk strobe when a key is accepted (or auto-repeats)
//   key_held   high while the accepted key remains pressed
//
// Parameters:
//   SCAN_DIV      clk cycles per scan tick (column dwell), >= 2
//   DEBOUNCE_CNT  consecutive identical ticks to accept press/release, >= 1
//   REPEAT_DELAY  held ticks before the first auto-repeat strobe
//   REPEAT_RATE   ticks between later auto-repeat strobes
//
// Build option:
//   KEYPAD_REPEAT_EN  when defined, a held key re-pulses key_valid after
//                     REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
//                     When undefined, there is exactly one strobe per press.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SCAN     | stepping through the columns, looking for a single low row
// DEBOUNCE | column frozen, counting ticks with the captured row pattern
// HELD     | key accepted, column frozen, counting all-high ticks to release
// ---------------------------------------------------------------------------
module keypad_encoder #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("keypad_encoder: SCAN_DIV must be at least 2");
    end
    if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
        $error("keypad_encoder: DEBOUNCE_CNT must be at least 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("keypad_encoder: REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    pat_q, pat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_d;
    logic          valid_d;
    logic          held_d;
    logic          rep_pulse;

    logic [3:0]    row_m, row_s;
    logic [PW-1:0] presc;
    logic          tick;

    logic          one_low;
    logic [1:0]    row_sel;

    // Two-flop synchronizer; rows are asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= rows;
            row_s <= row_m;
        end
    end

    // Free-running scan prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == PRESC_LAST);

    // Only a single low row is a valid key. Two or more low rows on one
    // column is a multi-press or ghost and is treated as no key.
    always_comb begin
        one_low = 1'b0;
        row_sel = 2'd0;
        case (row_s)
            4'b1110: begin one_low = 1'b1; row_sel = 2'd0; end
            4'b1101: begin one_low = 1'b1; row_sel = 2'd1; end
            4'b1011: begin one_low = 1'b1; row_sel = 2'd2; end
            4'b0111: begin one_low = 1'b1; row_sel = 2'd3; end
            default: begin one_low = 1'b0; row_sel = 2'd0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            row_idx_q <= 2'd0;
            pat_q     <= 4'hF;
            cnt_q     <= '0;
            cols      <= 4'b1110;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_idx_q <= row_idx_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            cols      <= ~(4'b0001 << col_d);
            key_code  <= code_d;
            key_valid <= valid_d | rep_pulse;
            key_held  <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_idx_d = row_idx_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        code_d    = key_code;
        valid_d   = 1'b0;
        held_d    = key_held;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (one_low) begin
                        row_idx_d = row_sel;
                        pat_d     = row_s;
                        if (CNT_LAST == '0) begin
                            // A single-tick debounce accepts on the capture tick.
                            code_d  = {row_sel, col_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end

                DEBOUNCE: begin
                    if (row_s == pat_q) begin
                        if (cnt_q == CNT_LAST) begin
                            code_d  = {row_idx_q, col_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end
                end

                HELD: begin
                    if (row_s == 4'hF) begin
                        if (cnt_q == CNT_LAST) begin
                            held_d  = 1'b0;
                            cnt_d   = '0;
                            col_d   = col_q + 2'd1;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        // Any low row during release restarts the release count.
                        cnt_d = '0;
                    end
                end

                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          rep_armed_q, rep_armed_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    // Outside HELD the counter is parked at zero, so entering HELD always
    // starts from a clean count. rep_armed selects the initial delay versus
    // the repeat rate.
    always_comb begin
        rep_d       = rep_q;
        rep_armed_d = rep_armed_q;
        rep_pulse   = 1'b0;
        if (state_q != HELD) begin
            rep_d       = '0;
            rep_armed_d = 1'b0;
        end else if (tick) begin
            if (row_s == 4'hF) begin
                rep_d       = '0;
                rep_armed_d = 1'b0;
            end else if (rep_q == (rep_armed_q ? REP_RATE_LAST : REP_DELAY_LAST)) begin
                rep_pulse   = 1'b1;
                rep_d       = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
Input-side companion to the count/display chain: scans a 4x4 matrix keypad and encodes one pressed key into a 4-bit code.
- Columns are driven active-low, one at a time.
- Rows are sampled through a synchronizer, and both press and release are debounced in the scan FSM.
- Emits a single-cycle key_valid strobe per accepted press, so the strobe can drive a counter enable or load directly.

Parameters:
SCAN_DIV, 50000, clk cycles per scan tick (column dwell time); min 2
DEBOUNCE_CNT, 4, consecutive identical ticks needed to accept press or release; min 1
REPEAT_DELAY, 50, ticks held before first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_RATE, 10, ticks between auto-repeat strobes (used only with KEYPAD_REPEAT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rows  input  4  keypad rows, active-low (external pull-ups), asynchronous
cols  output  4  keypad column drive, exactly one bit low at all times
key_code  output  4  code of last accepted key = row_idx*4 + col_idx
key_valid  output  1  one-cycle strobe when key_code is updated
key_held  output  1  high while accepted key remains pressed

Behaviour:
- Reset, asynchronous, active-high:
  - state=SCAN, col_idx=0, cols=4'b1110.
  - key_code=0, key_valid=0, key_held=0.
  - prescaler=0, debounce count=0.
  - Both synchronizer flops=4'hF.
  - Asserting rst mid-operation aborts any pending press; no strobe is issued.
- Synchronizer: rows pass through 2 flops to give row_s. All decisions use row_s only.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick=1 for one clk when prescaler==SCAN_DIV-1. All FSM transitions happen on tick cycles only.
- cols = ~(4'b0001 << col_idx), registered.
- SCAN, on tick:
  - row_s has exactly one bit low: capture row_idx, col_idx and the pattern; set cnt=1; go DEBOUNCE.
    - If DEBOUNCE_CNT==1, accept immediately (as in DEBOUNCE acceptance).
  - row_s==4'hF or more than one bit low (ghosting/multi-press): col_idx=(col_idx+1) mod 4; stay SCAN.
- DEBOUNCE (column frozen), on tick:
  - row_s==captured pattern: cnt++.
  - When cnt reaches DEBOUNCE_CNT:
    - key_code <= {row_idx, col_idx}[3:0] = row_idx*4+col_idx.
    - key_valid=1 for exactly one clk.
    - key_held=1; go HELD; cnt=0.
  - row_s differs: cnt=0; advance col_idx; go SCAN; no strobe.
- HELD (column frozen), on tick:
  - row_s==4'hF: cnt++. When cnt reaches DEBOUNCE_CNT: key_held=0; advance col_idx; go SCAN.
  - Any row low: cnt=0 (bounce during release); stay HELD.
  - A second key pressed in another column is not seen while HELD.
- key_code holds its value until the next accepted press; it is never cleared except by rst.
- key_valid and key_held are registered outputs.
- Latency: a clean press is accepted within 2 clk (sync) + at most 4 scan periods + (DEBOUNCE_CNT-1) scan periods (scan period = SCAN_DIV clk).
  - key_valid rises on the clk after the accepting tick.
- Wrap-around: col_idx 3 -> 0. Prescaler wraps without pause.

Optional Feature:
Macro: KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter counts ticks while the key is still pressed.
  - After REPEAT_DELAY ticks: key_valid pulses one clk (key_code unchanged).
  - Then a further pulse every REPEAT_RATE ticks.
  - The repeat counter clears on entering HELD, on any release-count tick, and on rst.
- Not defined: the repeat counter and parameters are unused. Exactly one key_valid per press, regardless of hold time.

Test Plan:
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DELAY=5, REPEAT_RATE=2.
1. Reset: rst=1 then 0, rows=4'hF -> cols=4'b1110, key_code=0, key_valid=0, key_held=0; cols steps 1110->1101->1011->0111->1110, one step every 4 clk.
2. Press row2/col1 (keypad model pulls rows[2] low when cols[1]=0), held stable -> exactly one key_valid pulse with key_code=4'd9, key_held=1, cols frozen at 4'b1101.
3. Bouncy press: rows[2] toggles every other tick for 4 ticks, then stable -> no strobe during bounce; single key_valid with key_code=9 after 3 stable ticks.
4. Release with bounce: rows return to 4'hF, with one low glitch after 2 high ticks -> key_held stays 1; clears only after 3 consecutive high ticks; scanning resumes at cols=4'b1011.
5. Ghost/multi-press: rows[0] and rows[3] low on col0 -> no strobe, scan continues; rst asserted mid-DEBOUNCE -> all outputs reset, no strobe.
6. KEYPAD_REPEAT_EN defined, key 15 (row3/col3) held 20 ticks -> first key_valid at acceptance, then at +5, +7, +9, ... ticks, key_code=15 throughout; without the macro -> one pulse only.
